// File: rtl/pipe_pkg.sv
// Shared definitions for the bus feeder: FSM encoding and parameter defaults.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRIVE = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH        = 8;
  localparam int unsigned DEF_DRIVE_CYCLES = 1;

endpackage

// File: rtl/pipe_feed8b_fifo2.sv
// Two-entry word FIFO; the caller guarantees no push when full and no pop when empty.
module fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pipe_feed8b.sv
// Feeds buffered words onto a shared tri-state bus: request, drive for a
// fixed number of cycles, then a one-cycle turnaround before the next word.
module pipe_feed8b
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned DRIVE_CYCLES = DEF_DRIVE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [WIDTH-1:0] data_out,
  output logic             drive_en
);

  localparam logic [3:0] DRIVE_LOAD = 4'(DRIVE_CYCLES - 1);

  state_t           state;
  state_t           next;
  logic [1:0]       count;
  logic [WIDTH-1:0] head;
  logic [3:0]       cnt;
  logic             push;
  logic             pop;
  logic             last;

  assign in_ready = (count < 2'd2);
  assign push     = in_valid && in_ready && !rst;
  assign last     = (cnt == 4'd0);
  assign pop      = (state == ST_DRIVE) && last;

  fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next;
  end

  always_comb begin
    next     = state;
    bus_req  = 1'b0;
    drive_en = 1'b0;
    case (state)
      ST_IDLE:  if (count != 2'd0) next = ST_REQ;
      ST_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) next = ST_DRIVE;
      end
      ST_DRIVE: begin
        bus_req  = 1'b1;
        drive_en = 1'b1;
        if (last) next = ST_TURN;
      end
      ST_TURN:  next = (count != 2'd0) ? ST_REQ : ST_IDLE;
      default:  next = ST_IDLE;
    endcase
  end

  // Counter runs down to zero; zero marks the final DRIVE cycle (the pop edge).
  always_ff @(posedge clk) begin
    if (rst)                              cnt <= '0;
    else if (state == ST_REQ && bus_gnt)  cnt <= DRIVE_LOAD;
    else if (state == ST_DRIVE && !last)  cnt <= cnt - 4'd1;
  end

  // Head is latched on DRIVE entry so data_out stays put for the whole burst.
  always_ff @(posedge clk) begin
    if (rst)                             data_out <= '0;
    else if (state == ST_REQ && bus_gnt) data_out <= head;
    else if (pop)                        data_out <= '0;
  end

endmodule
